// File: rtl/new_ln_unit_if.sv
// Host-side start/result bundle for the natural-logarithm unit.
// The host drives start/num and observes the result and handshake flags.
interface new_ln_unit_if;
   logic        start;
   logic [31:0] num;
   logic [31:0] ln_out;
   logic        busy;
   logic        done;
   logic        err;

   modport master (output start, num, input ln_out, busy, done, err);
   modport slave  (input start, num, output ln_out, busy, done, err);
endinterface

// File: rtl/new_ln_unit.sv
// Sequential ln(x): Q4.28 operand in, Q6.26 result out. The operand is normalised to 2^k*m,
// then an 8-term ln(1+u) Horner series is evaluated on one shared multiplier.
//   state    | meaning
//   S_IDLE   | wait for start, capture operand
//   S_NORM   | leading-one normalise, range-reduce m, reject x <= 0
//   S_HORNER | acc = c_j + u*acc, j = 7..1
//   S_FINAL  | acc = u*acc
//   S_SCALE  | ln_out = acc/4 + k*ln2
//   S_DONE   | one-cycle done pulse
module new_ln_unit (
   input  logic         clk,
   input  logic         res,
   new_ln_unit_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_NORM   = 3'd1;
   localparam logic [2:0] S_HORNER = 3'd2;
   localparam logic [2:0] S_FINAL  = 3'd3;
   localparam logic [2:0] S_SCALE  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [31:0]        ONE = 32'h1000_0000;
   localparam logic [31:0]        C8  = 32'hFE00_0000;
   localparam logic signed [31:0] LN2 = 32'sh02C5_C860;

   logic [2:0]        state;
   logic [2:0]        j;
   logic [31:0]       num_r;
   logic [31:0]       u;
   logic [31:0]       acc;
   logic signed [5:0] k;
   logic [31:0]       ln_out_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;

   logic [4:0]        p;
   logic [31:0]       m_raw;
   logic [31:0]       m_norm;
   logic signed [5:0] k_raw;
   logic signed [5:0] k_norm;
   logic              num_bad;

   always_comb begin
      p = 5'd0;
      for (int i = 0; i < 31; i++)
         if (num_r[i]) p = i[4:0];
      if (p >= 5'd28) m_raw = num_r >> (p - 5'd28);
      else            m_raw = num_r << (5'd28 - p);
      k_raw = $signed({1'b0, p}) - 6'sd28;
      // keep m in [0.75,1.5) so |u| stays small enough for the short series
      if (m_raw >= 32'h1800_0000) begin
         m_norm = m_raw >> 1;
         k_norm = k_raw + 6'sd1;
      end else begin
         m_norm = m_raw;
         k_norm = k_raw;
      end
   end

   assign num_bad = num_r[31] | (num_r == 32'h0);

   logic signed [63:0] prod;
   logic [31:0]        mul_q;
   logic [3:0]         unused_prod_hi;
   logic [27:0]        unused_prod_lo;
   assign prod = $signed({{32{u[31]}}, u}) * $signed({{32{acc[31]}}, acc});
   assign {unused_prod_hi, mul_q, unused_prod_lo} = prod;

   logic [31:0] coef;
   always_comb begin
      coef = 32'h0;
      case (j)
         3'd1: coef = 32'h1000_0000;
         3'd2: coef = 32'hF800_0000;
         3'd3: coef = 32'h0555_5555;
         3'd4: coef = 32'hFC00_0000;
         3'd5: coef = 32'h0333_3333;
         3'd6: coef = 32'hFD55_5555;
         3'd7: coef = 32'h0249_2492;
         default: coef = 32'h0;
      endcase
   end

   logic signed [31:0] k_ext;
   logic signed [31:0] kln2;
   logic signed [31:0] acc_sh;
   assign k_ext  = {{26{k[5]}}, k};
   assign kln2   = k_ext * LN2;
   assign acc_sh = $signed(acc) >>> 2;

   always_ff @(posedge clk) begin
      if (res) begin
         state    <= S_IDLE;
         j        <= 3'd0;
         num_r    <= 32'h0;
         u        <= 32'h0;
         acc      <= 32'h0;
         k        <= 6'sd0;
         ln_out_r <= 32'h0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  num_r  <= bus.num;
                  err_r  <= 1'b0;
                  busy_r <= 1'b1;
                  state  <= S_NORM;
               end
            end
            S_NORM: begin
               if (num_bad) begin
                  err_r    <= 1'b1;
                  ln_out_r <= 32'h0;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  u     <= m_norm - ONE;
                  k     <= k_norm;
                  acc   <= C8;
                  j     <= 3'd7;
                  state <= S_HORNER;
               end
            end
            S_HORNER: begin
               acc <= coef + mul_q;
               if (j == 3'd1) state <= S_FINAL;
               else           j     <= j - 3'd1;
            end
            S_FINAL: begin
               acc   <= mul_q;
               state <= S_SCALE;
            end
            S_SCALE: begin
               ln_out_r <= acc_sh + kln2;
               busy_r   <= 1'b0;
               done_r   <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               done_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ln_out = ln_out_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.err    = err_r;
endmodule

// File: tb/tb_new_ln_unit.sv
// Directed and random-sweep bench for new_ln_unit: exact latency/handshake checks,
// exact results where ln is representable, tolerance checks against a real-valued ln.
module tb_new_ln_unit;
   logic clk = 1'b0;
   logic res;
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   int   cnt0;
   logic [31:0] x;
   logic [31:0] held;
   real  xr;
   real  er;
   real  diff;

   new_ln_unit_if bus ();
   new_ln_unit dut (.clk(clk), .res(res), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
      int d;
      d = $signed(obs) - $signed(exp);
      if (d < 0) d = -d;
      total++;
      assert (d <= tol)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h (+/-%0d)", tag, obs, exp, tol);
      end
   endtask

   // Pulse start with x, follow the handshake and leave the bench in the done cycle.
   task automatic run_op(input logic [31:0] xin, input int lat_exp, input string tag);
      int   lat;
      logic busy_ok;
      @(negedge clk);
      bus.start = 1'b1;
      bus.num   = xin;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
      chk({tag, " busy"}, {31'd0, busy_ok & (bus.busy === 1'b0)}, 32'd1);
   endtask

   initial begin
      res       = 1'b1;
      bus.start = 1'b0;
      bus.num   = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst ln_out", bus.ln_out, 32'h0);
      chk("rst err", {31'd0, bus.err}, 32'd0);
      chk("rst busy", {31'd0, bus.busy}, 32'd0);
      chk("rst done", {31'd0, bus.done}, 32'd0);
      res = 1'b0;

      run_op(32'h1000_0000, 11, "one");
      chk("one ln", bus.ln_out, 32'h0);
      chk("one err", {31'd0, bus.err}, 32'd0);

      run_op(32'h2000_0000, 11, "two");
      chk("two ln", bus.ln_out, 32'h02C5_C860);
      held = bus.ln_out;
      repeat (3) @(negedge clk);
      chk("two hold", bus.ln_out, held);
      chk("two done low", {31'd0, bus.done}, 32'd0);

      run_op(32'h0000_0001, 11, "lsb");
      chk("lsb ln", bus.ln_out, 32'hB25E_1580);

      run_op(32'h2B7E_1516, 11, "e");
      chk_near("e ln", bus.ln_out, 32'h0400_0000, 16384);

      run_op(32'h1800_0000, 11, "1.5");
      chk_near("1.5 ln", bus.ln_out, 32'h019F_323F, 16384);

      run_op(32'h0000_0000, 2, "zero");
      chk("zero err", {31'd0, bus.err}, 32'd1);
      chk("zero ln", bus.ln_out, 32'h0);

      run_op(32'h2000_0000, 11, "two b");
      run_op(32'h8000_0000, 2, "neg");
      chk("neg err", {31'd0, bus.err}, 32'd1);
      chk("neg ln", bus.ln_out, 32'h0);
      repeat (3) @(negedge clk);
      chk("neg err hold", {31'd0, bus.err}, 32'd1);

      run_op(32'h2000_0000, 11, "clr");
      chk("clr err", {31'd0, bus.err}, 32'd0);
      chk("clr ln", bus.ln_out, 32'h02C5_C860);

      // abort in the fourth HORNER cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.num   = 32'h2B7E_1516;
      @(negedge clk);
      bus.start = 1'b0;
      cnt0 = done_cnt;
      repeat (4) @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      chk("abort ln", bus.ln_out, 32'h0);
      chk("abort busy", {31'd0, bus.busy}, 32'd0);
      chk("abort done", {31'd0, bus.done}, 32'd0);
      chk("abort err", {31'd0, bus.err}, 32'd0);
      repeat (15) @(negedge clk);
      chk("abort no done", 32'(done_cnt - cnt0), 32'd0);

      // second start while busy must be dropped
      cnt0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      bus.num   = 32'h2000_0000;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.num   = 32'h1000_0000;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (25) @(negedge clk);
      chk("busy start one done", 32'(done_cnt - cnt0), 32'd1);
      chk("busy start ln", bus.ln_out, 32'h02C5_C860);

      run_op(32'h1000_0000, 11, "after");
      chk("after ln", bus.ln_out, 32'h0);

      for (int n = 0; n < 1000; n++) begin
         x = ($urandom() & 32'h7FFF_FFFF) >> $urandom_range(30, 0);
         if (x == 32'h0) x = 32'h1;
         run_op(x, 11, "rnd");
         xr = real'(int'(x)) / 268435456.0;
         er = $ln(xr) * 67108864.0;
         diff = real'($signed(bus.ln_out)) - er;
         if (diff < 0.0) diff = -diff;
         total++;
         assert (diff <= 16384.0)
         else begin
            bad++;
            $error("FAIL rnd x=%h observed=%h expected=%f", x, bus.ln_out, er);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
